// File: rtl/sync_fifo_flags_pkg.sv
// Shared helpers for the single-clock flagged FIFO.
// Holds the depth derivation and a clog2-style width helper.
package fifo_pkg;

    function automatic int depth_of(input int asize);
        return 1 << asize;
    endfunction

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) w++;
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_fifo_flags_if.sv
// Data/flag bundle between a FIFO user and sync_fifo_flags.
// The user drives requests through master; the FIFO answers through slave.
interface sync_fifo_flags_if #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
);
    logic [DSIZE-1:0] wdata;
    logic             winc;
    logic             rinc;
    logic             clr_err;
    logic [DSIZE-1:0] rdata;
    logic             wfull;
    logic             rempty;
    logic             walmost_full;
    logic             ralmost_empty;
    logic [ASIZE:0]   count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wdata, winc, rinc, clr_err,
        input  rdata, wfull, rempty, walmost_full,
        input  ralmost_empty, count, overflow, underflow
    );

    modport slave (
        input  wdata, winc, rinc, clr_err,
        output rdata, wfull, rempty, walmost_full,
        output ralmost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_mem_2p.sv
// DEPTH x DSIZE register array: synchronous write port,
// asynchronous read port. Contents are deliberately not reset.
module fifo_mem_2p
    import fifo_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int DEPTH = 16,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [DSIZE-1:0] rdata
);

    logic [DSIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with watermarks, occupancy count, sticky
// overflow/underflow flags and optional first-word-fall-through.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 4,
    parameter int AFULL_TH  = depth_of(ASIZE) - 2,
    parameter int AEMPTY_TH = 2,
    parameter bit FWFT      = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    sync_fifo_flags_if.slave bus
);

    localparam int DEPTH = depth_of(ASIZE);
    localparam logic [ASIZE:0] FULL_CNT = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AF_CNT   = (ASIZE+1)'(AFULL_TH);
    localparam logic [ASIZE:0] AE_CNT   = (ASIZE+1)'(AEMPTY_TH);

    logic [ASIZE:0]   wptr;
    logic [ASIZE:0]   rptr;
    logic [ASIZE:0]   cnt;
    logic             full;
    logic             empty;
    logic             wr_en;
    logic             rd_en;
    logic [DSIZE-1:0] mem_rd;
    logic [DSIZE-1:0] rdata_q;
    logic             ovf_q;
    logic             unf_q;

    // MSB of the pointers separates full from empty once they wrap
    assign cnt   = wptr - rptr;
    assign full  = (cnt == FULL_CNT);
    assign empty = (cnt == '0);
    assign wr_en = bus.winc && !full;
    assign rd_en = bus.rinc && !empty;

    fifo_mem_2p #(
        .DSIZE (DSIZE),
        .DEPTH (DEPTH),
        .AW    (ASIZE)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wptr[ASIZE-1:0]),
        .wdata (bus.wdata),
        .raddr (rptr[ASIZE-1:0]),
        .rdata (mem_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            rdata_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) begin
                rptr    <= rptr + 1'b1;
                rdata_q <= mem_rd;
            end
            // a new error event wins over a clear in the same cycle
            if (bus.winc && full)    ovf_q <= 1'b1;
            else if (bus.clr_err)    ovf_q <= 1'b0;
            if (bus.rinc && empty)   unf_q <= 1'b1;
            else if (bus.clr_err)    unf_q <= 1'b0;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign bus.rdata = empty ? '0 : mem_rd;
        end else begin : g_std
            assign bus.rdata = rdata_q;
        end
    endgenerate

    assign bus.wfull         = full;
    assign bus.rempty        = empty;
    assign bus.walmost_full  = (cnt >= AF_CNT);
    assign bus.ralmost_empty = (cnt <= AE_CNT);
    assign bus.count         = cnt;
    assign bus.overflow      = ovf_q;
    assign bus.underflow     = unf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags in standard and FWFT read modes.
// Expected values are hand-derived from the FIFO's defined behaviour.
`timescale 1ns/1ps
module tb_sync_fifo_flags;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sync_fifo_flags_if #(.DSIZE(8), .ASIZE(4)) b0 ();
    sync_fifo_flags_if #(.DSIZE(8), .ASIZE(4)) b1 ();

    sync_fifo_flags #(.DSIZE(8), .ASIZE(4), .FWFT(1'b0)) u_std (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0.slave)
    );

    sync_fifo_flags #(.DSIZE(8), .ASIZE(4), .FWFT(1'b1)) u_fwft (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        b0.wdata = '0; b0.winc = 0; b0.rinc = 0; b0.clr_err = 0;
        b1.wdata = '0; b1.winc = 0; b1.rinc = 0; b1.clr_err = 0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        chk("rst_count",  b0.count, 0);
        chk("rst_rempty", b0.rempty, 1);
        chk("rst_wfull",  b0.wfull, 0);
        chk("rst_ae",     b0.ralmost_empty, 1);
        chk("rst_af",     b0.walmost_full, 0);
        chk("rst_ovf",    b0.overflow, 0);
        chk("rst_unf",    b0.underflow, 0);
        chk("rst_rdata",  b0.rdata, 0);

        // fill 15 words, watching both watermarks move
        for (int i = 0; i < 15; i++) begin
            b0.wdata = 8'(8'h11 + i);
            b0.winc  = 1;
            tick();
            chk("fill_cnt", b0.count, 32'(i + 1));
            chk("fill_ae",  b0.ralmost_empty, 32'((i + 1) <= 2));
            chk("fill_af",  b0.walmost_full, 32'((i + 1) >= 14));
        end
        chk("c15_wfull", b0.wfull, 0);
        b0.wdata = 8'h20;
        tick();
        b0.winc = 0;
        chk("c16_wfull", b0.wfull, 1);
        chk("c16_count", b0.count, 16);

        // write into a full FIFO
        b0.wdata = 8'hEE;
        b0.winc  = 1;
        tick();
        b0.winc = 0;
        chk("ovf_set",   b0.overflow, 1);
        chk("ovf_count", b0.count, 16);
        tick();
        chk("ovf_hold",  b0.overflow, 1);
        b0.clr_err = 1;
        tick();
        b0.clr_err = 0;
        chk("ovf_clr",   b0.overflow, 0);

        // drain in order; 0xEE must never appear
        for (int i = 0; i < 16; i++) begin
            b0.rinc = 1;
            tick();
            chk("drain", b0.rdata, (i < 15) ? 32'(8'h11 + i) : 32'h20);
        end
        b0.rinc = 0;
        chk("drain_empty", b0.rempty, 1);
        chk("drain_cnt",   b0.count, 0);

        // read from an empty FIFO
        b0.rinc = 1;
        tick();
        chk("unf_set",   b0.underflow, 1);
        chk("unf_rdata", b0.rdata, 32'h20);
        chk("unf_cnt",   b0.count, 0);
        b0.clr_err = 1;
        tick();
        chk("unf_win",   b0.underflow, 1);
        b0.rinc = 0;
        tick();
        b0.clr_err = 0;
        chk("unf_clr",   b0.underflow, 0);

        // standard one-word round trip
        b0.wdata = 8'hA5;
        b0.winc  = 1;
        tick();
        b0.winc = 0;
        chk("std_ne", b0.rempty, 0);
        b0.rinc = 1;
        tick();
        b0.rinc = 0;
        chk("std_rdata", b0.rdata, 32'hA5);
        chk("std_empty", b0.rempty, 1);
        chk("std_ae",    b0.ralmost_empty, 1);

        // FWFT: word visible right after the write edge
        chk("fw_pre_empty", b1.rempty, 1);
        chk("fw_pre_rdata", b1.rdata, 0);
        b1.wdata = 8'h3C;
        b1.winc  = 1;
        tick();
        b1.winc = 0;
        chk("fw_rdata", b1.rdata, 32'h3C);
        chk("fw_empty", b1.rempty, 0);
        chk("fw_count", b1.count, 1);
        b1.rinc = 1;
        tick();
        b1.rinc = 0;
        chk("fw_pop", b1.rempty, 1);

        // prime to count 8, then stream read+write together
        for (int i = 0; i < 8; i++) begin
            b0.wdata = 8'(8'h40 + i);
            b0.winc  = 1;
            tick();
        end
        chk("s_cnt8", b0.count, 8);
        chk("s_ae8",  b0.ralmost_empty, 0);
        chk("s_af8",  b0.walmost_full, 0);
        b0.rinc = 1;
        for (int i = 0; i < 40; i++) begin
            b0.wdata = 8'(8'h48 + i);
            tick();
            chk("s_rdata", b0.rdata, 32'(8'(8'h40 + i)));
            chk("s_count", b0.count, 8);
        end

        // asynchronous reset in the middle of the stream
        rst_n = 1'b0;
        #1;
        chk("ar_count",  b0.count, 0);
        chk("ar_rempty", b0.rempty, 1);
        chk("ar_rdata",  b0.rdata, 0);
        b0.winc = 0;
        b0.rinc = 0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_after", b0.count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
